// File: rtl/spi_rf_slave_pkg.sv
// Shared definitions for the SPI register-file slave: command word layout,
// read/write flag values and the frame FSM encoding.
package spi_rf_slave_pkg;

    localparam logic RF_WRITE_BIT = 1'b0;
    localparam logic RF_READ_BIT  = 1'b1;

    // Command / response word layout {RW, ADDR[6:0], DATA[7:0]}
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_EXEC    = 2'd2,
        ST_RD_WAIT = 2'd3
    } state_t;

    function automatic logic [15:0] pack_resp(input logic       rw,
                                              input logic [6:0] addr,
                                              input logic [7:0] data);
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the pin through the synchronizer chain and keep one delayed copy for edge detection
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  =  r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_rf_slave.sv
// SPI mode-3 slave front end of the register file. Receives 16-bit
// {RW, ADDR, DATA} frames, issues one write or read strobe per valid frame
// and shifts the previous frame's result back out on MISO.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | CSN high or frame start deferred; waiting for CSN low
// ST_SHIFT   | frame in progress; shifting MOSI in and MISO out
// ST_EXEC    | one cycle: latch addr/data, fire we or re strobe
// ST_RD_WAIT | waiting RD_LATENCY cycles for read data to capture
module spi_rf_slave
    import spi_rf_slave_pkg::*;
#(
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int RD_LATENCY  = 1
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       spi_sck_i,
    input  logic       spi_csn_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic [6:0] rf_addr_o,
    output logic [7:0] rf_wdata_o,
    output logic       rf_we_o,
    output logic       rf_re_o,
    input  logic [7:0] rf_rdata_i,
    output logic       frame_err_o,
    output logic [7:0] err_cnt_o
);

    // Bit counter saturates one past a full frame so overruns stay distinguishable
    localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);
    localparam int                LAT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RD_LATENCY);

    logic w_sck_rise, w_sck_fall, w_sck_lvl_unused;
    logic w_csn_rise, w_csn_fall, w_csn_lvl;
    logic w_mosi_lvl, w_mosi_rise_unused, w_mosi_fall_unused;

    state_t r_state, w_state_nxt;

    logic [CNT_W-1:0] r_bit_cnt, w_cnt_nxt;
    logic [15:0]      r_rx, r_tx, r_resp;
    logic [LAT_W-1:0] r_lat;
    logic             r_pend;
    logic             r_miso;
    logic [6:0]       r_addr;
    logic [7:0]       r_wdata;
    logic             r_we, r_re, r_err;
    logic [7:0]       r_err_cnt;
    logic             w_start, w_frame_bad;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .i_async (spi_sck_i),
        .o_level (w_sck_lvl_unused),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .i_async (spi_csn_i),
        .o_level (w_csn_lvl),
        .o_rise  (w_csn_rise),
        .o_fall  (w_csn_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_mosi (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .i_async (spi_mosi_i),
        .o_level (w_mosi_lvl),
        .o_rise  (w_mosi_rise_unused),
        .o_fall  (w_mosi_fall_unused)
    );

    // Count including an SCK rise seen on the same sample as CSN rise, so that edge counts first
    assign w_cnt_nxt = (w_sck_rise && (r_bit_cnt != CNT_SAT)) ? r_bit_cnt + 1'b1 : r_bit_cnt;

    // FSM state register
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state plus frame start / malformed-frame decisions
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_frame_bad = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A deferred start is dropped if CSN already went high again
                if ((w_csn_fall || r_pend) && !w_csn_lvl) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_csn_rise) begin
                    if (w_cnt_nxt == CNT_DONE) begin
                        w_state_nxt = ST_EXEC;
                    end else begin
                        w_frame_bad = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_EXEC: begin
                w_state_nxt = (r_rx[RW_BIT] == RF_READ_BIT) ? ST_RD_WAIT : ST_IDLE;
            end
            ST_RD_WAIT: begin
                if (r_lat == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Serial shift registers and bit counter
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_rx      <= '0;
            r_tx      <= '0;
            r_bit_cnt <= '0;
        end else if (w_start) begin
            r_tx      <= r_resp;
            r_rx      <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_bit_cnt <= w_cnt_nxt;
            if (w_sck_rise) begin
                r_rx <= {r_rx[14:0], w_mosi_lvl};
            end
            if (w_sck_fall) begin
                r_tx <= {r_tx[14:0], 1'b0};
            end
        end
    end

    // MISO: idle high while deselected, next tx bit on each SCK fall during a frame
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_miso <= 1'b1;
        end else if (w_csn_lvl) begin
            r_miso <= 1'b1;
        end else if ((r_state == ST_SHIFT) && w_sck_fall) begin
            r_miso <= r_tx[RW_BIT];
        end
    end

    // Register-file access: strobes, held address/data, read-latency timer and response word
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_lat   <= '0;
            r_resp  <= '0;
        end else begin
            r_we <= 1'b0;
            r_re <= 1'b0;
            if (r_state == ST_EXEC) begin
                r_addr  <= r_rx[ADDR_MSB:ADDR_LSB];
                r_wdata <= r_rx[DATA_MSB:DATA_LSB];
                r_lat   <= LAT_LOAD;
                if (r_rx[RW_BIT] == RF_READ_BIT) begin
                    r_re <= 1'b1;
                end else begin
                    r_we   <= 1'b1;
                    r_resp <= r_rx;
                end
            end else if (r_state == ST_RD_WAIT) begin
                if (r_lat == '0) begin
                    r_resp <= pack_resp(RF_READ_BIT, r_addr, rf_rdata_i);
                end else begin
                    r_lat <= r_lat - 1'b1;
                end
            end
        end
    end

    // Remember a CSN fall that arrives while an access is still completing
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_pend <= 1'b0;
        end else if (((r_state == ST_EXEC) || (r_state == ST_RD_WAIT)) && w_csn_fall) begin
            r_pend <= 1'b1;
        end
    end

    // Malformed-frame pulse and saturating error counter
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= w_frame_bad;
            if (w_frame_bad && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign spi_miso_o  = r_miso;
    assign rf_addr_o   = r_addr;
    assign rf_wdata_o  = r_wdata;
    assign rf_we_o     = r_we;
    assign rf_re_o     = r_re;
    assign frame_err_o = r_err;
    assign err_cnt_o   = r_err_cnt;

endmodule

// File: tb/tb_spi_rf_slave.sv
`timescale 1ns/1ps
module tb_spi_rf_slave;

    localparam int RD_LAT = 3;
    localparam int SYNC   = 2;
    localparam int HALF   = 5;   // clk_sys cycles per SCK half period (10 MHz SCK)

    logic       clk_sys    = 1'b0;
    logic       rst_n      = 1'b0;
    logic       spi_sck_i  = 1'b1;
    logic       spi_csn_i  = 1'b1;
    logic       spi_mosi_i = 1'b1;
    logic       spi_miso_o;
    logic [6:0] rf_addr_o;
    logic [7:0] rf_wdata_o;
    logic       rf_we_o, rf_re_o;
    logic [7:0] rf_rdata_i = 8'h00;
    logic       frame_err_o;
    logic [7:0] err_cnt_o;

    always #5 clk_sys = ~clk_sys;

    spi_rf_slave #(.FRAME_BITS(16), .SYNC_STAGES(SYNC), .RD_LATENCY(RD_LAT)) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .spi_sck_i   (spi_sck_i),
        .spi_csn_i   (spi_csn_i),
        .spi_mosi_i  (spi_mosi_i),
        .spi_miso_o  (spi_miso_o),
        .rf_addr_o   (rf_addr_o),
        .rf_wdata_o  (rf_wdata_o),
        .rf_we_o     (rf_we_o),
        .rf_re_o     (rf_re_o),
        .rf_rdata_i  (rf_rdata_i),
        .frame_err_o (frame_err_o),
        .err_cnt_o   (err_cnt_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: expected accesses in frame order, last response word, error counts
    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
        int         csn_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] resp_model     = 16'h0000;
    int          err_model      = 0;
    int          err_pulses     = 0;
    int          err_pulses_exp = 0;
    int          cyc            = 0;
    bit          rd_vary        = 1'b0;
    logic [7:0]  rd_fixed       = 8'h00;
    int          lens[4]        = '{8, 15, 17, 20};

    function automatic logic [7:0] rdata_at(input int n);
        return rd_vary ? 8'((n * 37 + 11) & 255) : rd_fixed;
    endfunction

    // Read data source: changes just after every clock edge, value is a function of the cycle index
    always @(posedge clk_sys) begin
        #1;
        cyc        = cyc + 1;
        rf_rdata_i = rdata_at(cyc);
    end

    // Scoreboard: each strobe must match the oldest expected access
    always @(negedge clk_sys) begin : mon
        exp_t e;
        if (rst_n) begin
            if (frame_err_o) err_pulses++;
            if (rf_we_o || rf_re_o) begin
                if (exp_q.size() == 0) begin
                    chk_eq("unexpected_strobe", {30'd0, rf_we_o, rf_re_o}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk_eq("strobe_kind", {30'd0, rf_we_o, rf_re_o}, e.rw ? 32'd1 : 32'd2);
                    chk_eq("rf_addr", {25'd0, rf_addr_o}, {25'd0, e.addr});
                    chk_eq("rf_wdata", {24'd0, rf_wdata_o}, {24'd0, e.data});
                    chk_eq("strobe_latency", cyc - e.csn_cyc, 2 + SYNC);
                    if (e.rw) resp_model = {1'b1, e.addr, rdata_at(cyc + RD_LAT)};
                    else      resp_model = {1'b0, e.addr, e.data};
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
        #1;
    endtask

    task automatic spi_bit(input logic b, output logic m);
        spi_sck_i  = 1'b0;
        spi_mosi_i = b;
        wait_cyc(HALF);
        m         = spi_miso_o;
        spi_sck_i = 1'b1;
        wait_cyc(HALF);
    endtask

    // One SPI frame of nbits, MSB first; checks the MISO word against the model
    task automatic send_frame(input int nbits, input logic [19:0] data, input int gap,
                              input bit same_edge, output logic [19:0] miso_w);
        logic        m;
        logic [15:0] snap;
        logic [31:0] want;
        exp_t        e;
        miso_w    = '0;
        spi_csn_i = 1'b0;
        wait_cyc(10);
        snap = resp_model;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (same_edge && i == 0) begin
                spi_sck_i  = 1'b0;
                spi_mosi_i = data[i];
                wait_cyc(HALF);
                m         = spi_miso_o;
                spi_sck_i = 1'b1;
                spi_csn_i = 1'b1;
            end else begin
                spi_bit(data[i], m);
            end
            miso_w = {miso_w[18:0], m};
        end
        if (!same_edge) begin
            wait_cyc(HALF);
            spi_csn_i = 1'b1;
        end
        if (nbits == 16) begin
            e.rw      = data[15];
            e.addr    = data[14:8];
            e.data    = data[7:0];
            e.csn_cyc = cyc;
            exp_q.push_back(e);
        end else begin
            err_pulses_exp++;
            if (err_model < 255) err_model++;
        end
        want = (nbits >= 16) ? ({16'd0, snap} << (nbits - 16)) : ({16'd0, snap} >> (16 - nbits));
        chk_eq("miso_word", {12'd0, miso_w}, want);
        wait_cyc(gap);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            wait_cyc(1);
            k++;
        end
        wait_cyc(10);
        chk_eq("strobes_outstanding", exp_q.size(), 0);
    endtask

    initial begin
        logic [19:0] mw;
        logic        m;

        // Reset values
        wait_cyc(4);
        chk_eq("rst_miso", {31'd0, spi_miso_o}, 32'd1);
        chk_eq("rst_strobes", {29'd0, rf_we_o, rf_re_o, frame_err_o}, 32'd0);
        chk_eq("rst_addr_wdata", {17'd0, rf_addr_o, rf_wdata_o}, 32'd0);
        chk_eq("rst_err_cnt", {24'd0, err_cnt_o}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(5);

        // Directed write
        send_frame(16, 20'h012A5, 20, 1'b0, mw);
        drain();
        chk_eq("wr_addr_held", {25'd0, rf_addr_o}, 32'h12);
        chk_eq("wr_data_held", {24'd0, rf_wdata_o}, 32'hA5);

        // Two reads of 0x05 with fixed data 0x3C
        rd_fixed = 8'h3C;
        send_frame(16, 20'h08500, 20, 1'b0, mw);
        chk_eq("resp_after_write", {16'd0, mw[15:0]}, 32'h12A5);
        send_frame(16, 20'h08500, 20, 1'b0, mw);
        chk_eq("read_resp_853C", {16'd0, mw[15:0]}, 32'h853C);
        drain();

        // Cycle-varying read data: captured byte is the one RD_LAT cycles after rf_re_o
        rd_vary = 1'b1;
        send_frame(16, 20'h09A00, 20, 1'b0, mw);
        send_frame(16, 20'h01111, 20, 1'b0, mw);
        drain();

        // Short and overrun frames
        send_frame(12, 20'h00ABC, 20, 1'b0, mw);
        send_frame(20, 20'hFFFFF, 20, 1'b0, mw);
        wait_cyc(10);
        chk_eq("err_cnt_two", {24'd0, err_cnt_o}, 32'd2);
        chk_eq("err_pulses_two", err_pulses, 2);
        send_frame(16, 20'h03355, 20, 1'b0, mw);
        chk_eq("resp_unchanged_after_errs", {16'd0, mw[15:0]}, 32'h1111);
        drain();

        // Last SCK rise coincident with CSN rise, then back-to-back reads (deferred start)
        send_frame(16, 20'h04C7E, 20, 1'b1, mw);
        send_frame(16, 20'h08100, 2, 1'b0, mw);
        send_frame(16, 20'h08200, 2, 1'b0, mw);
        send_frame(16, 20'h00000, 20, 1'b0, mw);
        drain();

        // Randomized frames
        for (int k = 0; k < 40; k++) begin
            int          nb;
            logic [19:0] d;
            nb = ($urandom_range(0, 4) == 0) ? lens[$urandom_range(0, 3)] : 16;
            d  = 20'($urandom);
            send_frame(nb, d, $urandom_range(2, 30), ($urandom_range(0, 7) == 0), mw);
        end
        drain();
        chk_eq("rand_err_cnt", {24'd0, err_cnt_o}, err_model);
        chk_eq("rand_err_pulses", err_pulses, err_pulses_exp);

        // Error counter saturation
        for (int k = 0; k < 300; k++) begin
            send_frame(3, 20'h5, 4, 1'b0, mw);
        end
        wait_cyc(10);
        chk_eq("err_cnt_sat", {24'd0, err_cnt_o}, 32'hFF);
        chk_eq("sat_err_pulses", err_pulses, err_pulses_exp);

        // Reset after bit 9 of a write frame
        spi_csn_i = 1'b0;
        wait_cyc(10);
        for (int i = 15; i >= 7; i--) begin
            logic [15:0] w;
            w = 16'h2B6D;
            spi_bit(w[i], m);
        end
        rst_n = 1'b0;
        wait_cyc(3);
        chk_eq("midrst_miso", {31'd0, spi_miso_o}, 32'd1);
        chk_eq("midrst_err_cnt", {24'd0, err_cnt_o}, 32'd0);
        spi_csn_i  = 1'b1;
        spi_sck_i  = 1'b1;
        spi_mosi_i = 1'b1;
        exp_q.delete();
        resp_model     = 16'h0000;
        err_model      = 0;
        err_pulses     = 0;
        err_pulses_exp = 0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(30);
        chk_eq("postrst_no_strobe_miso", {29'd0, rf_we_o, rf_re_o, spi_miso_o}, 32'd1);
        send_frame(16, 20'h07F01, 20, 1'b0, mw);
        chk_eq("postrst_resp_zero", {16'd0, mw[15:0]}, 32'h0000);
        drain();
        chk_eq("postrst_err_pulses", err_pulses, 0);
        chk_eq("idle_miso", {31'd0, spi_miso_o}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
